// File: rtl/ws2812_pkg.sv
// Shared timing defaults, FSM encoding and sizing helper for the WS2812 serializer.
package ws2812_pkg;

  // Default bit-cell timing for a 12 MHz system clock
  localparam int unsigned T0H_CYCLES_DEF   = 4;
  localparam int unsigned T1H_CYCLES_DEF   = 8;
  localparam int unsigned BIT_CYCLES_DEF   = 15;
  localparam int unsigned LATCH_CYCLES_DEF = 720;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // Timer width large enough for the longer of a bit cell and the latch period
  function automatic int unsigned timer_width(input int unsigned bit_cycles,
                                              input int unsigned latch_cycles);
    int unsigned m;
    m = (bit_cycles > latch_cycles) ? bit_cycles : latch_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Wrapping cycle counter with terminal-count and high-phase compare.
module ws2812_bit_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  input  logic [W-1:0] high_i,
  output logic         tc_c,
  output logic         high_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_c   = (count_q == limit_i);
  assign high_c = (count_q < high_i);

  // Hold at zero while cleared, otherwise count and wrap at the terminal value
  always_comb begin
    count_d = count_q + W'(1);
    if (clr_i || tc_c) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ws2812_serializer.sv
// Pulls channel bytes from upstream and drives them MSB-first as WS2812 bit cells.
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYCLES   = T0H_CYCLES_DEF,
  parameter int unsigned T1H_CYCLES   = T1H_CYCLES_DEF,
  parameter int unsigned BIT_CYCLES   = BIT_CYCLES_DEF,
  parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_request,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  localparam int unsigned TW = timer_width(BIT_CYCLES, LATCH_CYCLES);

  if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) &&
        (T1H_CYCLES < BIT_CYCLES) && (LATCH_CYCLES >= BIT_CYCLES))) begin : g_param_check
    $error("ws2812_serializer: illegal timing parameters");
  end

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          dout_q, dout_d;
  logic          done_q, done_d;
  logic [TW-1:0] timer_limit;
  logic [TW-1:0] high_thresh;
  logic          timer_tc;
  logic          timer_high;

  assign timer_limit = (state_q == ST_LATCH) ? TW'(LATCH_CYCLES - 1) : TW'(BIT_CYCLES - 1);
  assign high_thresh = sr_q[7] ? TW'(T1H_CYCLES) : TW'(T0H_CYCLES);

  // One timer serves both bit cells and the latch period; idle keeps it at zero
  ws2812_bit_timer #(
    .W (TW)
  ) u_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr_i   (state_q == ST_IDLE),
    .limit_i (timer_limit),
    .high_i  (high_thresh),
    .tc_c    (timer_tc),
    .high_c  (timer_high)
  );

  // Next-state, byte fetch and line level
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_idx_d    = bit_idx_q;
    dout_d       = 1'b0;
    done_d       = 1'b0;
    data_request = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && data_valid) begin
          data_request = 1'b1;
          sr_d         = data;
          bit_idx_d    = 3'd0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        dout_d = timer_high;
        if (timer_tc) begin
          if (bit_idx_q != 3'd7) begin
            sr_d      = {sr_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q + 3'd1;
          end else if (data_valid) begin
            data_request = 1'b1;
            sr_d         = data;
            bit_idx_d    = 3'd0;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (timer_tc) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_LATCH;
      end
    endcase
  end

  // State and output registers; reset parks in LATCH so the line idles low first
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_LATCH;
      sr_q      <= 8'd0;
      bit_idx_q <= 3'd0;
      dout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_idx_q <= bit_idx_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign dout = dout_q;

endmodule
